// File: rtl/softmax_row_core.sv
// Row-wise softmax over signed fixed-point stream beats: base-2 exponent approximation,
// per-row sum, restoring reciprocal divider and per-lane output scaling.
module softmax_row_core #(
    parameter int unsigned TOUT          = 32,
    parameter int unsigned DAT_DW        = 8,
    parameter int unsigned MAX_ROW_BEATS = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [15:0]              row_len,
    input  logic [15:0]              num_rows,
    input  logic [3:0]               in_scale,
    input  logic [3:0]               out_scale,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [TOUT*DAT_DW-1:0]   s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [TOUT*DAT_DW-1:0]   m_data
);
    localparam int unsigned MaxLen = MAX_ROW_BEATS * TOUT;
    localparam int unsigned SumW   = 16 + $clog2(MaxLen);
    localparam int unsigned BeatW  = (MAX_ROW_BEATS > 1) ? $clog2(MAX_ROW_BEATS) : 1;
    localparam int unsigned XW     = DAT_DW + 3;
    localparam int unsigned EW     = 16;
    localparam logic [DAT_DW-1:0] OutMax = {1'b0, {(DAT_DW-1){1'b1}}};

    typedef enum logic [2:0] {StIdle, StLoad, StExp, StDiv, StOut} state_e;

    state_e                     state_q, state_d;
    logic [BeatW-1:0]           beat_q, beat_d;
    logic [BeatW-1:0]           last_beat_q, last_beat_d;
    logic [15:0]                row_q, row_d;
    logic [15:0]                rows_q, rows_d;
    logic [15:0]                len_q, len_d;
    logic [3:0]                 in_sc_q, in_sc_d;
    logic [3:0]                 out_sc_q, out_sc_d;
    logic signed [DAT_DW-1:0]   max_q, max_d;
    logic [SumW-1:0]            sum_q, sum_d;
    logic [SumW-1:0]            rem_q, rem_d;
    logic [16:0]                quo_q, quo_d;
    logic [4:0]                 div_q, div_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;

    // Each slot holds the raw input in its low DAT_DW bits, later overwritten with E.
    logic [TOUT*EW-1:0]         buf_q [MAX_ROW_BEATS];
    logic                       buf_we;
    logic [TOUT*EW-1:0]         buf_wdata;
    logic [TOUT*EW-1:0]         rd_beat;

    logic [TOUT-1:0]            lane_on;
    logic signed [DAT_DW-1:0]   beat_max;
    logic [TOUT*EW-1:0]         load_data;
    logic [TOUT*EW-1:0]         exp_data;
    logic [SumW-1:0]            exp_sum;
    logic [SumW:0]              rem_sh;
    logic                       rem_ge;
    logic                       cfg_bad;

    // d*log2(e) ~= d*1.4375, then 2^-q split into integer shift and linear fraction.
    function automatic logic [EW-1:0] exp_approx(input logic [DAT_DW-1:0] x,
                                                 input logic [DAT_DW-1:0] mx,
                                                 input logic [3:0]        sh);
        logic signed [XW-1:0] d;
        logic signed [XW-1:0] y;
        logic [XW-1:0]        q;
        logic [XW-1:0]        ip;
        logic [XW-1:0]        fp;
        logic [EW-1:0]        num;
        d   = {{3{x[DAT_DW-1]}}, x} - {{3{mx[DAT_DW-1]}}, mx};
        y   = d + (d >>> 1) - (d >>> 4);
        q   = -y;
        ip  = q >> sh;
        fp  = q & ~({XW{1'b1}} << sh);
        num = 16'h8000 - (EW'(fp) << (4'd14 - sh));
        if (ip >= XW'(16)) begin
            return '0;
        end
        return num >> ip[3:0];
    endfunction

    function automatic logic [DAT_DW-1:0] scale_out(input logic [EW-1:0] e,
                                                    input logic [16:0]   r,
                                                    input logic [3:0]    sh);
        logic [32:0] prod;
        logic [32:0] val;
        prod = {17'b0, e} * {16'b0, r};
        val  = prod >> (5'd31 - {1'b0, sh});
        if (val > 33'(OutMax)) begin
            return OutMax;
        end
        return val[DAT_DW-1:0];
    endfunction

    assign rd_beat = buf_q[beat_q];
    assign cfg_bad = (row_len == 16'd0) || (num_rows == 16'd0) || (32'(row_len) > MaxLen);

    // Bring in one bit of the 2^31 dividend per cycle; only the first bit is set.
    assign rem_sh = {rem_q, div_q == 5'd0};
    assign rem_ge = rem_sh >= {1'b0, sum_q};

    always_comb begin
        for (int i = 0; i < TOUT; i++) begin
            lane_on[i] = (32'(beat_q) * TOUT + 32'(i)) < 32'(len_q);
        end
    end

    always_comb begin
        beat_max  = {1'b1, {(DAT_DW-1){1'b0}}};
        load_data = '0;
        exp_data  = '0;
        exp_sum   = '0;
        m_data    = '0;
        for (int i = 0; i < TOUT; i++) begin
            load_data[i*EW +: DAT_DW] = s_data[i*DAT_DW +: DAT_DW];
            if (lane_on[i] && ($signed(s_data[i*DAT_DW +: DAT_DW]) > beat_max)) begin
                beat_max = $signed(s_data[i*DAT_DW +: DAT_DW]);
            end
            if (lane_on[i]) begin
                exp_data[i*EW +: EW] = exp_approx(rd_beat[i*EW +: DAT_DW], max_q, in_sc_q);
                exp_sum = exp_sum + SumW'(exp_data[i*EW +: EW]);
            end
            if (m_valid && lane_on[i]) begin
                m_data[i*DAT_DW +: DAT_DW] = scale_out(rd_beat[i*EW +: EW], quo_q, out_sc_q);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        last_beat_d = last_beat_q;
        row_d       = row_q;
        rows_d      = rows_q;
        len_d       = len_q;
        in_sc_d     = in_sc_q;
        out_sc_d    = out_sc_q;
        max_d       = max_q;
        sum_d       = sum_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        div_d       = div_q;
        done_d      = 1'b0;
        err_d       = err_q;
        buf_we      = 1'b0;
        buf_wdata   = load_data;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (cfg_bad) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        err_d       = 1'b0;
                        len_d       = row_len;
                        rows_d      = num_rows;
                        in_sc_d     = in_scale;
                        out_sc_d    = out_scale;
                        last_beat_d = BeatW'((32'(row_len) + TOUT - 32'd1) / TOUT - 32'd1);
                        beat_d      = '0;
                        row_d       = '0;
                        state_d     = StLoad;
                    end
                end
            end
            StLoad: begin
                if (s_valid) begin
                    buf_we = 1'b1;
                    if ((beat_q == '0) || (beat_max > max_q)) begin
                        max_d = beat_max;
                    end
                    if (beat_q == last_beat_q) begin
                        beat_d  = '0;
                        sum_d   = '0;
                        state_d = StExp;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            StExp: begin
                buf_we    = 1'b1;
                buf_wdata = exp_data;
                sum_d     = sum_q + exp_sum;
                if (beat_q == last_beat_q) begin
                    beat_d  = '0;
                    rem_d   = '0;
                    quo_d   = '0;
                    div_d   = '0;
                    state_d = StDiv;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            StDiv: begin
                rem_d = rem_ge ? SumW'(rem_sh - {1'b0, sum_q}) : rem_sh[SumW-1:0];
                quo_d = {quo_q[15:0], rem_ge};
                if (div_q == 5'd31) begin
                    beat_d  = '0;
                    state_d = StOut;
                end else begin
                    div_d = div_q + 5'd1;
                end
            end
            StOut: begin
                if (m_ready) begin
                    if (beat_q == last_beat_q) begin
                        beat_d = '0;
                        if (row_q == rows_q - 16'd1) begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end else begin
                            row_d   = row_q + 16'd1;
                            state_d = StLoad;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            beat_q      <= '0;
            last_beat_q <= '0;
            row_q       <= '0;
            rows_q      <= '0;
            len_q       <= '0;
            in_sc_q     <= '0;
            out_sc_q    <= '0;
            max_q       <= '0;
            sum_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            last_beat_q <= last_beat_d;
            row_q       <= row_d;
            rows_q      <= rows_d;
            len_q       <= len_d;
            in_sc_q     <= in_sc_d;
            out_sc_q    <= out_sc_d;
            max_q       <= max_d;
            sum_q       <= sum_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            div_q       <= div_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[beat_q] <= buf_wdata;
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign err     = err_q;
    assign s_ready = (state_q == StLoad);
    assign m_valid = (state_q == StOut);

endmodule

// File: tb/tb_softmax_row_core.sv
// Bench for softmax_row_core: directed cases plus randomized rows against an arithmetic model.
module tb_softmax_row_core;
    localparam int unsigned TOUT = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned MRB  = 8;
    localparam int unsigned MAXN = TOUT * MRB;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [15:0]          row_len = '0;
    logic [15:0]          num_rows = '0;
    logic [3:0]           in_scale = '0;
    logic [3:0]           out_scale = '0;
    logic                 busy, done, err;
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic [TOUT*DW-1:0]   s_data = '0;
    logic                 m_valid;
    logic                 m_ready = 1'b0;
    logic [TOUT*DW-1:0]   m_data;

    softmax_row_core #(.TOUT(TOUT), .DAT_DW(DW), .MAX_ROW_BEATS(MRB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .row_len(row_len), .num_rows(num_rows),
        .in_scale(in_scale), .out_scale(out_scale), .busy(busy), .done(done), .err(err),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int sready_cnt = 0;
    int row_x [MAXN];
    int exp_out [MAXN];
    logic [TOUT*DW-1:0] last_data;

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (s_ready === 1'b1) sready_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Softmax approximation computed straight from the arithmetic rules.
    task automatic model_row(input int n, input int ins, input int outs);
        int mx, d, y, q, ip, fp;
        longint s, r, p;
        int e [MAXN];
        mx = row_x[0];
        for (int k = 1; k < n; k++) if (row_x[k] > mx) mx = row_x[k];
        s = 0;
        for (int k = 0; k < n; k++) begin
            d = row_x[k] - mx;
            y = d + (d >>> 1) - (d >>> 4);
            q = -y;
            ip = q >> ins;
            fp = q % (1 << ins);
            e[k] = (ip >= 16) ? 0 : ((32768 - fp * (1 << (14 - ins))) >> ip);
            s += e[k];
        end
        r = (longint'(1) << 31) / s;
        for (int k = 0; k < n; k++) begin
            p = (longint'(e[k]) * r) >> (31 - outs);
            exp_out[k] = (p > 127) ? 127 : int'(p);
        end
    endtask

    task automatic send_row(input int n);
        int nb, guard, idx;
        nb = (n + TOUT - 1) / TOUT;
        for (int b = 0; b < nb; b++) begin
            s_valid = 1'b1;
            for (int l = 0; l < TOUT; l++) begin
                idx = b * TOUT + l;
                s_data[l*DW +: DW] = (idx < n) ? DW'(row_x[idx]) : DW'($urandom);
            end
            guard = 0;
            while (s_ready !== 1'b1 && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 200) chk("s_ready_timeout", 0, 1);
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    task automatic recv_row(input int n, input int r, input bit stall);
        int nb, got, cyc, lat, guard, idx;
        bit seen, held_v;
        logic [TOUT*DW-1:0] held;
        nb = (n + TOUT - 1) / TOUT;
        got = 0; cyc = 0; lat = 1; guard = 0; seen = 0; held_v = 0; held = '0;
        while (got < nb && guard < 3000) begin
            m_ready = stall ? (((cyc / 3) % 2) == 1) : 1'b1;
            cyc++;
            if (held_v) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_hold", m_data, held);
            end
            if (m_valid === 1'b1) begin
                if (!seen) begin
                    seen = 1;
                    chk("latency", lat, nb + 33);
                end
                if (m_ready) begin
                    for (int l = 0; l < TOUT; l++) begin
                        idx = got * TOUT + l;
                        chk($sformatf("row%0d_beat%0d_lane%0d", r, got, l), m_data[l*DW +: DW],
                            (idx < n) ? exp_out[idx] : 0);
                    end
                    last_data = m_data;
                    got++;
                    held_v = 0;
                end else begin
                    held   = m_data;
                    held_v = 1;
                end
            end
            if (!seen) lat++;
            @(negedge clk);
            guard++;
        end
        if (got < nb) chk("m_valid_timeout", got, nb);
    endtask

    task automatic run_job(input int n, input int rows, input int ins, input int outs,
                           input bit stall, input bit preset);
        int d0;
        d0 = done_cnt;
        start = 1'b1; row_len = 16'(n); num_rows = 16'(rows);
        in_scale = 4'(ins); out_scale = 4'(outs);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("err_cleared", err, 0);
        for (int r = 0; r < rows; r++) begin
            if (!preset) begin
                for (int k = 0; k < n; k++) row_x[k] = int'($urandom_range(0, 255)) - 128;
            end
            model_row(n, ins, outs);
            send_row(n);
            recv_row(n, r, stall);
        end
        chk("done_after_last", done, 1);
        chk("idle_after_last", busy, 0);
        @(negedge clk);
        chk("done_single_pulse", done_cnt - d0, 1);
    endtask

    task automatic err_job(input int n, input int rows);
        int d0, s0;
        d0 = done_cnt; s0 = sready_cnt;
        start = 1'b1; row_len = 16'(n); num_rows = 16'(rows);
        @(negedge clk);
        start = 1'b0;
        chk("cfg_err_set", err, 1);
        chk("cfg_err_done", done, 1);
        chk("cfg_err_idle", busy, 0);
        @(negedge clk);
        chk("cfg_err_done_low", done, 0);
        chk("cfg_err_sticky", err, 1);
        repeat (3) @(negedge clk);
        chk("cfg_err_no_sready", sready_cnt - s0, 0);
        chk("cfg_err_done_count", done_cnt - d0, 1);
    endtask

    initial begin
        int guard;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        rst_n = 1'b1;

        // Equal inputs: uniform distribution.
        for (int k = 0; k < 4; k++) row_x[k] = 10;
        run_job(4, 1, 6, 6, 0, 1);
        chk("equal_lane3", last_data[3*DW +: DW], 16);

        // Single element row.
        row_x[0] = 5;
        run_job(1, 1, 6, 6, 0, 1);
        chk("single_lane0", last_data[0 +: DW], 64);
        chk("single_lane1", last_data[DW +: DW], 0);

        // Two elements, fractional exponent.
        row_x[0] = 64; row_x[1] = 0;
        run_job(2, 1, 6, 6, 0, 1);
        chk("two_lane0", last_data[0 +: DW], 46);
        chk("two_lane1", last_data[DW +: DW], 17);

        // Multi-row with partial last beat and output backpressure.
        run_job(9, 2, 6, 6, 1, 0);

        // Configuration errors.
        err_job(0, 1);
        err_job(int'(MAXN) + 1, 1);
        err_job(4, 0);

        // Full-length row and randomized jobs.
        run_job(int'(MAXN), 1, 4, 7, 1, 0);
        for (int j = 0; j < 6; j++) begin
            run_job(int'($urandom_range(1, MAXN)), int'($urandom_range(1, 3)),
                    int'($urandom_range(0, 14)), int'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 0);
        end

        // Reset while the second output beat is pending.
        for (int k = 0; k < 8; k++) row_x[k] = int'($urandom_range(0, 255)) - 128;
        start = 1'b1; row_len = 16'd8; num_rows = 16'd1; in_scale = 4'd5; out_scale = 4'd6;
        @(negedge clk);
        start = 1'b0;
        send_row(8);
        m_ready = 1'b1;
        guard = 0;
        while (m_valid !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("rst_test_first_beat", m_valid, 1);
        @(negedge clk);
        chk("rst_test_second_beat", m_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_m_data", m_data, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_job(7, 1, 3, 5, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
